// File: rtl/sc_to_binary_multi_if.sv
// Host-side port bundle of the stochastic-to-binary converter: control, SC sample
// inputs and the valid/ready result channel.
interface sc_to_binary_multi_if #(
  parameter int CHANNELS = 4,
  parameter int SCALE_W  = 9
);
  localparam int OUT_W = SCALE_W + 1;

  logic                      start;
  logic                      clear;
  logic [SCALE_W-1:0]        maxnum;
  logic                      sc_valid;
  logic [CHANNELS-1:0]       sc_bit;
  logic                      busy;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS*OUT_W-1:0] bnum;

  modport master (
    output start, clear, maxnum, sc_valid, sc_bit, out_ready,
    input  busy, out_valid, bnum
  );

  modport slave (
    input  start, clear, maxnum, sc_valid, sc_bit, out_ready,
    output busy, out_valid, bnum
  );
endinterface

// File: rtl/sc_to_binary_multi.sv
// Multi-channel stochastic-to-binary converter: counts ones over 2**LOG_LEN valid samples
// and scales by maxnum. Define SC_BIPOLAR_EN for signed bipolar decoding.
module sc_to_binary_multi #(
  parameter int CHANNELS = 4,
  parameter int LOG_LEN  = 8,
  parameter int SCALE_W  = 9
) (
  input logic                 clk,
  input logic                 rst_n,
  sc_to_binary_multi_if.slave bus
);
  localparam int OUT_W = SCALE_W + 1;
  localparam int CNT_W = LOG_LEN + 1;
`ifdef SC_BIPOLAR_EN
  localparam int PROD_W = LOG_LEN + 3 + SCALE_W + 1;
  localparam logic [CNT_W-1:0] L_CNT = CNT_W'(1 << LOG_LEN);
`else
  localparam int PROD_W = CNT_W + SCALE_W;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << LOG_LEN) - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, DONE} state_t;

  state_t                    state;
  state_t                    state_nx;
  logic [SCALE_W-1:0]        maxnum_q;
  logic [CNT_W-1:0]          ones_q [CHANNELS];
  logic [CNT_W-1:0]          sample_q;
  logic [PROD_W-1:0]         prod_d [CHANNELS];
  logic [PROD_W-1:0]         prod_q [CHANNELS];
  logic                      load_q;
  logic                      out_valid_q;
  logic [CHANNELS*OUT_W-1:0] bnum_q;
  logic [CHANNELS*OUT_W-1:0] bnum_d;
  logic                      last_sample;
  logic                      handshake;

  assign last_sample   = (state == ACCUM) && bus.sc_valid && (sample_q == LAST);
  assign handshake     = out_valid_q && bus.out_ready;
  assign bus.busy      = (state == ACCUM) || (state == SCALE);
  assign bus.out_valid = out_valid_q;
  assign bus.bnum      = bnum_q;

  // Next-state logic; clear overrides every other transition.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = ACCUM;
      ACCUM:   if (last_sample) state_nx = SCALE;
      SCALE:   state_nx = DONE;
      DONE:    if (handshake) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.clear) state_nx = IDLE;
  end

`ifdef SC_BIPOLAR_EN
  logic signed [PROD_W-1:0] diff_ext [CHANNELS];
  logic signed [PROD_W-1:0] max_ext;
  logic signed [LOG_LEN+2:0] diff [CHANNELS];

  // Bipolar value is 2*ones - L, scaled as a signed product.
  always_comb begin
    max_ext = PROD_W'($signed({1'b0, maxnum_q}));
    for (int i = 0; i < CHANNELS; i++) begin
      diff[i]     = $signed({1'b0, ones_q[i], 1'b0}) - $signed({2'b00, L_CNT});
      diff_ext[i] = PROD_W'(diff[i]);
      prod_d[i]   = diff_ext[i] * max_ext;
    end
  end

  always_comb begin
    bnum_d = '0;
    for (int i = 0; i < CHANNELS; i++)
      bnum_d[i*OUT_W +: OUT_W] = OUT_W'($signed(prod_q[i]) >>> LOG_LEN);
  end
`else
  always_comb begin
    for (int i = 0; i < CHANNELS; i++)
      prod_d[i] = PROD_W'(ones_q[i]) * PROD_W'(maxnum_q);
  end

  // Truncating divide by L; the result never exceeds maxnum so the lane MSB is zero.
  always_comb begin
    bnum_d = '0;
    for (int i = 0; i < CHANNELS; i++)
      bnum_d[i*OUT_W +: OUT_W] = {1'b0, SCALE_W'(prod_q[i] >> LOG_LEN)};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Products are registered in SCALE; bnum and out_valid load one cycle later in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maxnum_q    <= '0;
      sample_q    <= '0;
      load_q      <= 1'b0;
      out_valid_q <= 1'b0;
      bnum_q      <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        ones_q[i] <= '0;
        prod_q[i] <= '0;
      end
    end else begin
      load_q <= 1'b0;
      if (bus.clear) begin
        sample_q    <= '0;
        out_valid_q <= 1'b0;
        for (int i = 0; i < CHANNELS; i++) ones_q[i] <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              maxnum_q <= bus.maxnum;
              sample_q <= '0;
              for (int i = 0; i < CHANNELS; i++) ones_q[i] <= '0;
            end
          end
          ACCUM: begin
            if (bus.sc_valid) begin
              sample_q <= sample_q + 1'b1;
              for (int i = 0; i < CHANNELS; i++)
                ones_q[i] <= ones_q[i] + CNT_W'(bus.sc_bit[i]);
            end
          end
          SCALE: begin
            load_q <= 1'b1;
            for (int i = 0; i < CHANNELS; i++) prod_q[i] <= prod_d[i];
          end
          DONE: begin
            if (load_q) begin
              bnum_q      <= bnum_d;
              out_valid_q <= 1'b1;
            end else if (handshake) begin
              out_valid_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sc_to_binary_multi.sv
// Self-checking bench for sc_to_binary_multi (LOG_LEN=4, 4 channels); honours SC_BIPOLAR_EN.
module tb_sc_to_binary_multi;
  logic clk;
  logic rst_n;

  sc_to_binary_multi_if #(.CHANNELS(4), .SCALE_W(9)) bus();

  sc_to_binary_multi #(.CHANNELS(4), .LOG_LEN(4), .SCALE_W(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  bit          cmp_en = 1'b0;
  logic        mdl_busy;
  logic        mdl_valid;
  logic [39:0] mdl_bnum;
  int          cnt [4];
  logic [3:0]  pat [16];

  // Expected lanes from the ones counts of the window the bench actually sent.
  function automatic logic [39:0] modelResult(int maxv);
    logic [39:0] r;
    int num;
    int q;
    r = '0;
    for (int ch = 0; ch < 4; ch++) begin
`ifdef SC_BIPOLAR_EN
      num = (2 * cnt[ch] - 16) * maxv;
      q = num / 16;
      if ((num % 16) != 0 && num < 0) q = q - 1;
`else
      num = cnt[ch] * maxv;
      q = num / 16;
`endif
      r[ch*10 +: 10] = 10'(q);
    end
    return r;
  endfunction

  function automatic int laneOf(logic [39:0] v, int i);
    logic [9:0] l;
    l = v[i*10 +: 10];
`ifdef SC_BIPOLAR_EN
    return int'($signed(l));
`else
    return int'(l);
`endif
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      tests += 3;
      if (bus.busy !== mdl_busy) begin
        fails++;
        $display("[TB] FAIL busy @%0t: got %b, expected %b", $time, bus.busy, mdl_busy);
      end
      if (bus.out_valid !== mdl_valid) begin
        fails++;
        $display("[TB] FAIL out_valid @%0t: got %b, expected %b", $time, bus.out_valid, mdl_valid);
      end
      if (bus.bnum !== mdl_bnum) begin
        fails++;
        $display("[TB] FAIL bnum @%0t: got %h, expected %h", $time, bus.bnum, mdl_bnum);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // abortMode: 0 none, 1 clear at sample abortAt, 2 reset at sample abortAt.
  task automatic applyStimulus(input int maxv, input int stallEvery, input bit startNoise,
                               input int abortAt, input int abortMode);
    for (int ch = 0; ch < 4; ch++) cnt[ch] = 0;
    bus.maxnum = 9'(maxv);
    bus.start  = 1'b1;
    tick();
    mdl_busy   = 1'b1;
    bus.start  = startNoise;
    bus.maxnum = 9'h1AB;
    for (int k = 0; k < 16; k++) begin
      if (abortMode != 0 && k == abortAt) begin
        if (abortMode == 1) begin
          bus.clear    = 1'b1;
          bus.sc_valid = 1'b1;
          bus.sc_bit   = 4'hF;
          tick();
          bus.clear    = 1'b0;
          bus.sc_valid = 1'b0;
          bus.start    = 1'b0;
          mdl_busy     = 1'b0;
        end else begin
          rst_n        = 1'b0;
          bus.sc_valid = 1'b0;
          bus.start    = 1'b0;
          mdl_busy     = 1'b0;
          mdl_valid    = 1'b0;
          mdl_bnum     = '0;
          tick();
          rst_n = 1'b1;
          tick();
        end
        return;
      end
      if (stallEvery > 0 && k > 0 && (k % stallEvery) == 0) begin
        repeat (3) begin
          bus.sc_valid = 1'b0;
          bus.sc_bit   = 4'hF;
          tick();
        end
      end
      bus.sc_valid = 1'b1;
      bus.sc_bit   = pat[k];
      for (int ch = 0; ch < 4; ch++) cnt[ch] += int'(pat[k][ch]);
      tick();
    end
    bus.sc_valid = 1'b0;
    bus.sc_bit   = 4'h0;
    tick();
    mdl_busy = 1'b0;
    tick();
    mdl_valid = 1'b1;
    mdl_bnum  = modelResult(maxv);
  endtask

  task automatic finishHandshake(input int hold, input bit startNoise);
    bus.out_ready = 1'b0;
    bus.start     = startNoise;
    repeat (hold) tick();
    bus.out_ready = 1'b1;
    tick();
    mdl_valid     = 1'b0;
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.clear     = 1'b0;
    bus.maxnum    = '0;
    bus.sc_valid  = 1'b0;
    bus.sc_bit    = '0;
    bus.out_ready = 1'b0;
    mdl_busy      = 1'b0;
    mdl_valid     = 1'b0;
    mdl_bnum      = '0;
    cmp_en        = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Test 1: 16/8/0/5 ones at maxnum 300.
    for (int k = 0; k < 16; k++) pat[k] = {1'(k < 5), 1'b0, 1'(k % 2 == 0), 1'b1};
    applyStimulus(300, 0, 1'b0, -1, 0);
`ifdef SC_BIPOLAR_EN
    checkOutput("t1_lane0", laneOf(bus.bnum, 0), 300);
    checkOutput("t1_lane1", laneOf(bus.bnum, 1), 0);
    checkOutput("t1_lane2", laneOf(bus.bnum, 2), -300);
    checkOutput("t1_lane3", laneOf(bus.bnum, 3), -113);
`else
    checkOutput("t1_lane0", laneOf(bus.bnum, 0), 300);
    checkOutput("t1_lane1", laneOf(bus.bnum, 1), 150);
    checkOutput("t1_lane2", laneOf(bus.bnum, 2), 0);
    checkOutput("t1_lane3", laneOf(bus.bnum, 3), 93);
`endif
    finishHandshake(0, 1'b0);

    // Test 2: same window with stalls.
    applyStimulus(300, 4, 1'b0, -1, 0);
    checkOutput("t2_lane3", laneOf(bus.bnum, 3), laneOf(modelResult(300), 3));
    finishHandshake(0, 1'b0);

    // Test 3: back-pressure with start noise in ACCUM and DONE.
    applyStimulus(300, 4, 1'b1, -1, 0);
    finishHandshake(5, 1'b1);

    // Test 4: reset mid-window, then fresh conversion.
    applyStimulus(300, 0, 1'b0, 7, 2);
    for (int k = 0; k < 16; k++) pat[k] = {1'b0, 1'b1, 1'(k < 3), 1'(k % 2 == 0)};
    applyStimulus(100, 0, 1'b0, -1, 0);
`ifdef SC_BIPOLAR_EN
    checkOutput("t4_lane0", laneOf(bus.bnum, 0), 0);
`else
    checkOutput("t4_lane0", laneOf(bus.bnum, 0), 50);
`endif
    finishHandshake(1, 1'b0);

    // Test 5: clear after 10 samples, clear+start in IDLE, then a good conversion.
    applyStimulus(300, 0, 1'b0, 10, 1);
    repeat (3) tick();
    bus.start = 1'b1;
    bus.clear = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.clear = 1'b0;
    repeat (2) tick();
    applyStimulus(200, 0, 1'b0, -1, 0);
    finishHandshake(0, 1'b0);

    // Test 6: 4/16/8/0 ones at maxnum 100.
    for (int k = 0; k < 16; k++) pat[k] = {1'b0, 1'(k % 2 == 1), 1'b1, 1'(k < 4)};
    applyStimulus(100, 0, 1'b0, -1, 0);
`ifdef SC_BIPOLAR_EN
    checkOutput("t6_lane0", laneOf(bus.bnum, 0), -50);
    checkOutput("t6_lane1", laneOf(bus.bnum, 1), 100);
    checkOutput("t6_lane2", laneOf(bus.bnum, 2), 0);
    checkOutput("t6_lane3", laneOf(bus.bnum, 3), -100);
`else
    checkOutput("t6_lane0", laneOf(bus.bnum, 0), 25);
    checkOutput("t6_lane1", laneOf(bus.bnum, 1), 100);
    checkOutput("t6_lane2", laneOf(bus.bnum, 2), 50);
    checkOutput("t6_lane3", laneOf(bus.bnum, 3), 0);
`endif
    finishHandshake(0, 1'b0);

    // Full-scale boundary: every channel all ones at maxnum 511.
    for (int k = 0; k < 16; k++) pat[k] = 4'hF;
    applyStimulus(511, 0, 1'b0, -1, 0);
    checkOutput("fs_lane2", laneOf(bus.bnum, 2), 511);
    finishHandshake(2, 1'b0);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
